// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: steps one decoded instruction through
// fetch, decode, execute, memory, write-back and PC update.
module exec_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ctl_branch,
    input  logic       ctl_mem_read,
    input  logic       ctl_mem_write,
    input  logic       ctl_reg_write,
    input  logic       ctl_reg_branch,
    input  logic       ctl_ra_write,
    input  logic       ctl_is_mult,
    input  logic       branch_taken,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       mem_req,
    output logic       mem_we,
    output logic       rf_we,
    output logic [1:0] rf_wsel,
    output logic       pc_update,
    output logic [1:0] pc_sel,
    output logic       busy,
    output logic       done,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WB_LO, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t           state, next;
    logic [CNT_W-1:0] wait_cnt;
    logic             taken;
    logic             abort;
    logic             in_mem_phase;

    logic       ir_load_d, mem_req_d, mem_we_d, rf_we_d, pc_update_d, busy_d, done_d, mem_err_d;
    logic [1:0] rf_wsel_d, pc_sel_d;

    assign in_mem_phase = (state == S_FETCH) || (state == S_MEM);

    // The wait counter holds cycles already spent without an ack, so the
    // MEM_WAIT_MAX-th silent cycle aborts while an ack in that cycle still wins.
    always_comb begin
        next  = state;
        abort = 1'b0;
        case (state)
            S_IDLE:   if (start) next = S_FETCH;
            S_FETCH, S_MEM: begin
                if (mem_ack) begin
                    next = (state == S_FETCH) ? S_DECODE : S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    next  = S_IDLE;
                    abort = 1'b1;
                end
            end
            S_DECODE: next = S_EXEC;
            S_EXEC:   next = (ctl_mem_read || ctl_mem_write) ? S_MEM : S_WB;
            S_WB:     next = ctl_is_mult ? S_WB_LO : S_DONE;
            S_WB_LO:  next = S_DONE;
            S_DONE:   next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the next state and registered below.
    always_comb begin
        ir_load_d   = (next == S_DECODE);
        mem_req_d   = (next == S_FETCH) || (next == S_MEM);
        mem_we_d    = (next == S_MEM) && ctl_mem_write;
        rf_we_d     = 1'b0;
        rf_wsel_d   = 2'b00;
        pc_update_d = (next == S_DONE);
        done_d      = (next == S_DONE);
        pc_sel_d    = 2'b00;
        busy_d      = (next != S_IDLE);
        mem_err_d   = mem_err;
        if (next == S_WB) begin
            rf_we_d   = ctl_reg_write || ctl_ra_write || ctl_is_mult;
            rf_wsel_d = ctl_ra_write ? 2'b01 : (ctl_is_mult ? 2'b10 : 2'b00);
        end else if (next == S_WB_LO) begin
            rf_we_d   = 1'b1;
            rf_wsel_d = 2'b11;
        end
        if (next == S_DONE && taken) pc_sel_d = ctl_reg_branch ? 2'b10 : 2'b01;
        if (state == S_IDLE && start) mem_err_d = 1'b0;
        else if (abort)               mem_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            taken    <= 1'b0;
        end else begin
            state <= next;
            if (state == S_EXEC) taken <= ctl_branch && branch_taken;
            if ((next == S_FETCH || next == S_MEM) && next != state) wait_cnt <= '0;
            else if (in_mem_phase && !mem_ack)                        wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_load   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rf_we     <= 1'b0;
            rf_wsel   <= 2'b00;
            pc_update <= 1'b0;
            pc_sel    <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            ir_load   <= ir_load_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            rf_we     <= rf_we_d;
            rf_wsel   <= rf_wsel_d;
            pc_update <= pc_update_d;
            pc_sel    <= pc_sel_d;
            busy      <= busy_d;
            done      <= done_d;
            mem_err   <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised scoreboard bench for exec_sequencer: stimulus pushes the expected
// event sequence of each instruction, a monitor pops and compares observed events.
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ctl_branch = 1'b0, ctl_mem_read = 1'b0, ctl_mem_write = 1'b0, ctl_reg_write = 1'b0;
    logic       ctl_reg_branch = 1'b0, ctl_ra_write = 1'b0, ctl_is_mult = 1'b0, branch_taken = 1'b0;
    logic       mem_ack = 1'b0;
    logic       ir_load, mem_req, mem_we, rf_we, pc_update, busy, done, mem_err;
    logic [1:0] rf_wsel, pc_sel;

    exec_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ctl_branch(ctl_branch), .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write),
        .ctl_reg_write(ctl_reg_write), .ctl_reg_branch(ctl_reg_branch), .ctl_ra_write(ctl_ra_write),
        .ctl_is_mult(ctl_is_mult), .branch_taken(branch_taken), .mem_ack(mem_ack),
        .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .pc_update(pc_update), .pc_sel(pc_sel), .busy(busy), .done(done), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    localparam int NEVER = 99;   // wait value meaning "never ack"
    localparam int LIMIT = 15;

    // event kinds: 0 mem request start, 1 ir_load, 2 rf write, 3 done, 4 abort
    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int fw_cfg = 0, mw_cfg = 0;
    int seg_n = 0;

    function automatic string kname(int k);
        case (k)
            0: return "mreq";
            1: return "ir_load";
            2: return "rf_write";
            3: return "done";
            default: return "abort";
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(int kind, int val);
        exp_q.push_back(kind * 65536 + val);
    endtask

    // Reference model: the event stream one instruction should produce.
    task automatic expect_instr(bit br, bit mr, bit mwr, bit rw, bit rb, bit ra, bit mult, bit bt,
                                int fw, int mw);
        bit mem = mr | mwr;
        int lat;
        int sel;
        push(0, 0);
        if (fw >= LIMIT) begin push(4, 1); return; end
        push(1, 1);
        if (mem) begin
            push(0, int'(mwr));
            if (mw >= LIMIT) begin push(4, 1); return; end
        end
        if (mult) begin
            push(2, ra ? 1 : 2);
            push(2, 3);
        end else if (ra || rw) begin
            push(2, ra ? 1 : 0);
        end
        sel = (br && bt) ? (rb ? 2 : 1) : 0;
        lat = 5 + fw + (mem ? 1 + mw : 0) + (mult ? 1 : 0);
        push(3, 4096 + sel * 256 + lat);
    endtask

    task automatic got(int kind, int val);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got %0d expected no event", kname(kind), val);
        end else begin
            chk({"sb_", kname(kind)}, kind * 65536 + val, exp_q.pop_front());
        end
    endtask

    // Monitor: turns output activity into events, independent of the stimulus.
    bit pb = 0, preq = 0, pdone = 0;
    int lat = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pb = 0; preq = 0; pdone = 0; lat = 0;
        end else begin
            if (busy) lat = pb ? lat + 1 : 1;
            if (mem_req && !preq) got(0, int'(mem_we) + 2 * int'(mem_err));
            if (ir_load) got(1, 1);
            if (rf_we) got(2, int'(rf_wsel));
            if (done) got(3, int'(pc_update) * 4096 + int'(pc_sel) * 256 + lat);
            if (!busy && pb && !pdone) got(4, int'(mem_err));
            pb = busy; preq = mem_req; pdone = done;
        end
    end

    // Memory responder: ack in cycle wait+1 of each request; stray acks otherwise.
    int idx = 0, seg = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            idx = 0; seg_n = 0; mem_ack = 1'b0;
        end else begin
            if (!busy) seg_n = 0;
            if (mem_req) begin
                if (idx == 0) begin seg = seg_n; seg_n = seg_n + 1; end
                idx = idx + 1;
                mem_ack = (idx == ((seg == 0) ? fw_cfg : mw_cfg) + 1);
            end else begin
                idx = 0;
                mem_ack = ($urandom_range(3) == 0);
            end
        end
    end

    task automatic run_instr(bit br, bit mr, bit mwr, bit rw, bit rb, bit ra, bit mult, bit bt,
                             int fw, int mw);
        int n;
        @(posedge clk); #1;
        ctl_branch = br; ctl_mem_read = mr; ctl_mem_write = mwr; ctl_reg_write = rw;
        ctl_reg_branch = rb; ctl_ra_write = ra; ctl_is_mult = mult; branch_taken = bt;
        fw_cfg = fw; mw_cfg = mw;
        expect_instr(br, mr, mwr, rw, rb, ra, mult, bt, fw, mw);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            start = ($urandom_range(3) == 0);   // ignored while busy
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (n >= 300) chk("timeout_busy", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        int r, f, m;
        #12;
        chk("reset_outputs", int'({ir_load, mem_req, mem_we, rf_we, rf_wsel, pc_update, pc_sel, busy, done, mem_err}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // br mr mw rw rb ra mult bt fw mw
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 2, 0);          // ALU, done at cycle 7
        run_instr(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);          // load
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 1, 2);          // store
        run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);          // mult
        run_instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);          // branch taken -> L
        run_instr(1, 0, 0, 0, 1, 0, 0, 1, 1, 0);          // taken, register target
        run_instr(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);          // call
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // not taken
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, NEVER, 0);      // fetch abort
        chk("abort_mem_err", int'(mem_err), 1);
        chk("abort_busy", int'(busy), 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, LIMIT - 1, 0);  // ack on the limit cycle
        chk("clear_mem_err", int'(mem_err), 0);
        run_instr(0, 1, 0, 1, 0, 0, 0, 0, 0, NEVER);      // MEM abort
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, LIMIT - 1);

        // Reset in the middle of a memory access.
        @(posedge clk); #1;
        ctl_mem_read = 1'b1; ctl_mem_write = 1'b0; ctl_reg_write = 1'b1; ctl_is_mult = 1'b0;
        ctl_branch = 1'b0; ctl_ra_write = 1'b0;
        fw_cfg = 0; mw_cfg = NEVER;
        push(0, 0); push(1, 1); push(0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r = 0;
        while (seg_n < 2 && r < 50) begin @(posedge clk); #1; r++; end
        chk("reach_mem", int'(seg_n >= 2), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({ir_load, mem_req, mem_we, rf_we, rf_wsel, pc_update, pc_sel, busy, done, mem_err}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", int'(busy), 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            f = $urandom_range(15);
            f = (f == 0) ? NEVER : (f == 1) ? LIMIT - 1 : f % 5;
            m = $urandom_range(15);
            m = (m == 0) ? NEVER : (m == 1) ? LIMIT - 1 : m % 4;
            run_instr(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7], f, m);
            repeat ($urandom_range(2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
